ifetch_ctrl: RTL

Instruction-fetch controller that sequences the instruction ROM. It owns the program counter and drives the ROM word address. It registers each fetched instruction into a one-entry output stage with a valid/ready handshake toward decode. It handles branch redirects and halts the core when it reaches the zero-word program terminator or leaves ROM range.

---
 rtl/ifetch_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, sequences the ROM and registers each word into a
// one-entry valid/ready output stage; redirects flush the stage, the zero word or leaving ROM halts.
module ifetch_ctrl #(
    parameter int N     = 32,
    parameter int PC_W  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [5:0]       imem_addr,
    input  logic [N-1:0]     imem_q,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [N-1:0]     inst,
    output logic [PC_W-1:0]  inst_pc,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [N-1:0]      inst_q, inst_d;
    logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    logic in_range;
    logic fetch_ok;
    logic load;
    logic handshake;

    assign in_range  = (pc_q[PC_W-1:8] == '0);
    assign fetch_ok  = in_range && (imem_q != '0);
    assign handshake = inst_valid_q && inst_ready;
    assign load      = (state_q == RUN) && (!inst_valid_q || inst_ready) && !redirect_valid;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (load && !fetch_ok) begin
            state_d = HALT;
        end
    end

    // FSM: outputs
    always_comb begin
        halted = (state_q == HALT);
    end

    // Redirect outranks load; a handshake alone only empties the stage.
    always_comb begin
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            inst_valid_d = 1'b0;
            pc_d         = redirect_pc & ~PC_W'(3);
        end else if (load) begin
            if (fetch_ok) begin
                inst_d       = imem_q;
                inst_pc_d    = pc_q;
                inst_valid_d = 1'b1;
                pc_d         = pc_q + PC_W'(4);
            end else begin
                inst_valid_d = 1'b0;
            end
        end else if (handshake) begin
            inst_valid_d = 1'b0;
        end

        if (handshake && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= '0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            inst_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q[7:2];
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_count = fetch_count_q;

endmodule
